// File: rtl/dmem_lsu.sv
// Load/store initiator for the dual-port data memory: scalar/vector loads and stores
// plus a strided 16-lane gather, with valid/ready request and response channels.
module dmem_lsu #(
    parameter int unsigned LANES = 16,
    parameter int unsigned A_AW  = 18,
    parameter int unsigned B_AW  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [31:0]           req_addr,
    input  logic [15:0]           req_stride,
    input  logic [15:0]           req_wdata_a,
    input  logic [LANES*16-1:0]   req_wdata_b,
    output logic                  mem_w_enable,
    output logic                  mem_src_sel,
    output logic [31:0]           mem_addr,
    output logic [15:0]           mem_w_data_a,
    output logic [LANES*16-1:0]   mem_w_data_b,
    input  logic [15:0]           mem_q_a,
    input  logic [LANES*16-1:0]   mem_q_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_error,
    output logic [15:0]           rsp_data_a,
    output logic [LANES*16-1:0]   rsp_data_b
);

    localparam int unsigned DW = LANES * 16;
    localparam int unsigned LW = $clog2(LANES);

    localparam logic [2:0] OP_LD     = 3'b000;
    localparam logic [2:0] OP_ST     = 3'b001;
    localparam logic [2:0] OP_VLD    = 3'b010;
    localparam logic [2:0] OP_VST    = 3'b011;
    localparam logic [2:0] OP_GATHER = 3'b100;

    localparam logic [LW:0] LAST_ISSUE = (LW+1)'(LANES - 1);
    localparam logic [LW:0] LANE_END   = (LW+1)'(LANES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_GATHER, S_RESP} state_t;

    state_t        state, state_n;
    logic [2:0]    op_q, op_n;
    logic [15:0]   stride_q, stride_n;
    logic [31:0]   gaddr_q, gaddr_n;
    logic [LW:0]   lane_q, lane_n;
    logic          issue_err_q, issue_err_n;
    logic          cap_err_q, cap_err_n;
    logic [LW-1:0] cap_idx;

    logic            req_ready_n, mem_w_enable_n, mem_src_sel_n;
    logic [31:0]     mem_addr_n;
    logic [15:0]     mem_w_data_a_n, rsp_data_a_n;
    logic [DW-1:0]   mem_w_data_b_n, rsp_data_b_n;
    logic            rsp_valid_n, rsp_error_n;

    // Range/legality check for one memory access
    function automatic logic acc_err(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            OP_LD, OP_ST, OP_GATHER: return |addr[31:A_AW];
            OP_VLD, OP_VST:          return |addr[31:B_AW];
            default:                 return 1'b1;
        endcase
    endfunction

    // Gather lane being captured this cycle is the one issued in the previous cycle
    assign cap_idx = LW'(lane_q - (LW+1)'(1));

    always_comb begin
        state_n        = state;
        op_n           = op_q;
        stride_n       = stride_q;
        gaddr_n        = gaddr_q;
        lane_n         = lane_q;
        issue_err_n    = 1'b0;
        cap_err_n      = issue_err_q;
        req_ready_n    = req_ready;
        mem_w_enable_n = 1'b0;
        mem_src_sel_n  = 1'b0;
        mem_addr_n     = '0;
        mem_w_data_a_n = '0;
        mem_w_data_b_n = '0;
        rsp_valid_n    = rsp_valid;
        rsp_error_n    = rsp_error;
        rsp_data_a_n   = rsp_data_a;
        rsp_data_b_n   = rsp_data_b;

        case (state)
            S_IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid) begin
                    // Memory controls are registered here so they appear during ISSUE
                    op_n           = req_op;
                    stride_n       = req_stride;
                    gaddr_n        = req_addr + 32'(req_stride);
                    lane_n         = '0;
                    issue_err_n    = acc_err(req_op, req_addr);
                    req_ready_n    = 1'b0;
                    mem_addr_n     = req_addr;
                    mem_src_sel_n  = (req_op == OP_VLD) || (req_op == OP_VST);
                    mem_w_data_a_n = req_wdata_a;
                    mem_w_data_b_n = req_wdata_b;
                    mem_w_enable_n = ((req_op == OP_ST) || (req_op == OP_VST))
                                     && !acc_err(req_op, req_addr);
                    rsp_data_a_n   = '0;
                    rsp_data_b_n   = '0;
                    rsp_error_n    = 1'b0;
                    state_n        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (op_q)
                    OP_LD, OP_VLD: state_n = S_CAPTURE;
                    OP_GATHER: begin
                        mem_addr_n  = gaddr_q;
                        issue_err_n = acc_err(OP_GATHER, gaddr_q);
                        gaddr_n     = gaddr_q + 32'(stride_q);
                        lane_n      = (LW+1)'(1);
                        state_n     = S_GATHER;
                    end
                    default: begin
                        rsp_valid_n = 1'b1;
                        rsp_error_n = issue_err_q;
                        state_n     = S_RESP;
                    end
                endcase
            end
            S_CAPTURE: begin
                if (op_q == OP_LD) rsp_data_a_n = cap_err_q ? 16'h0 : mem_q_a;
                else               rsp_data_b_n = cap_err_q ? '0 : mem_q_b;
                rsp_error_n = cap_err_q;
                rsp_valid_n = 1'b1;
                state_n     = S_RESP;
            end
            S_GATHER: begin
                rsp_data_b_n[16*cap_idx +: 16] = cap_err_q ? 16'h0 : mem_q_a;
                rsp_error_n = rsp_error | cap_err_q;
                if (lane_q == LANE_END) begin
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                end else begin
                    lane_n = lane_q + (LW+1)'(1);
                    if (lane_q < LAST_ISSUE) begin
                        mem_addr_n  = gaddr_q;
                        issue_err_n = acc_err(OP_GATHER, gaddr_q);
                        gaddr_n     = gaddr_q + 32'(stride_q);
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_q         <= '0;
            stride_q     <= '0;
            gaddr_q      <= '0;
            lane_q       <= '0;
            issue_err_q  <= 1'b0;
            cap_err_q    <= 1'b0;
            req_ready    <= 1'b1;
            mem_w_enable <= 1'b0;
            mem_src_sel  <= 1'b0;
            mem_addr     <= '0;
            mem_w_data_a <= '0;
            mem_w_data_b <= '0;
            rsp_valid    <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_data_a   <= '0;
            rsp_data_b   <= '0;
        end else begin
            state        <= state_n;
            op_q         <= op_n;
            stride_q     <= stride_n;
            gaddr_q      <= gaddr_n;
            lane_q       <= lane_n;
            issue_err_q  <= issue_err_n;
            cap_err_q    <= cap_err_n;
            req_ready    <= req_ready_n;
            mem_w_enable <= mem_w_enable_n;
            mem_src_sel  <= mem_src_sel_n;
            mem_addr     <= mem_addr_n;
            mem_w_data_a <= mem_w_data_a_n;
            mem_w_data_b <= mem_w_data_b_n;
            rsp_valid    <= rsp_valid_n;
            rsp_error    <= rsp_error_n;
            rsp_data_a   <= rsp_data_a_n;
            rsp_data_b   <= rsp_data_b_n;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural dual-port memory (1-cycle read latency).
module tb_dmem_lsu;

    localparam logic [2:0] OP_LD     = 3'b000;
    localparam logic [2:0] OP_ST     = 3'b001;
    localparam logic [2:0] OP_VLD    = 3'b010;
    localparam logic [2:0] OP_VST    = 3'b011;
    localparam logic [2:0] OP_GATHER = 3'b100;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [2:0]   req_op;
    logic [31:0]  req_addr;
    logic [15:0]  req_stride, req_wdata_a;
    logic [255:0] req_wdata_b;
    logic         mem_w_enable, mem_src_sel;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_w_data_a, mem_q_a;
    logic [255:0] mem_w_data_b, mem_q_b;
    logic         rsp_valid, rsp_ready, rsp_error;
    logic [15:0]  rsp_data_a;
    logic [255:0] rsp_data_b;

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_stride(req_stride),
        .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
        .mem_w_enable(mem_w_enable), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
        .mem_w_data_a(mem_w_data_a), .mem_w_data_b(mem_w_data_b),
        .mem_q_a(mem_q_a), .mem_q_b(mem_q_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_error(rsp_error),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b)
    );

    // Shared storage: vector word v occupies scalar words 16v..16v+15
    logic [15:0] mem [0:262143];
    int we_cnt = 0;

    always @(posedge clk) begin
        if (mem_w_enable) begin
            we_cnt <= we_cnt + 1;
            if (!mem_src_sel) mem[mem_addr[17:0]] <= mem_w_data_a;
            else for (int i = 0; i < 16; i++)
                mem[{mem_addr[13:0], 4'(i)}] <= mem_w_data_b[16*i +: 16];
        end
        mem_q_a <= mem[mem_addr[17:0]];
        for (int i = 0; i < 16; i++)
            mem_q_b[16*i +: 16] <= mem[{mem_addr[13:0], 4'(i)}];
    end

    int           n_tests = 0, n_fail = 0;
    int           lat, w0;
    logic         sel, we_issue, er;
    logic [15:0]  da;
    logic [255:0] db, pat, gexp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for the response, capture it, consume it if rsp_ready
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [15:0] stride,
                          input logic [15:0] wa, input logic [255:0] wb);
        req_op = op; req_addr = addr; req_stride = stride;
        req_wdata_a = wa; req_wdata_b = wb; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sel = mem_src_sel;
        we_issue = mem_w_enable;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_arrived", 256'(rsp_valid), 256'(1));
        da = rsp_data_a; db = rsp_data_b; er = rsp_error;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_addr = '0; req_stride = '0; req_wdata_a = '0; req_wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_we", 256'(mem_w_enable), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // Scalar store then load
        w0 = we_cnt;
        do_req(OP_ST, 32'h100, 16'h0, 16'hBEEF, 256'h0);
        chk("st_lat", 256'(lat), 256'(2));
        chk("st_err", 256'(er), 256'(0));
        chk("st_we_issue", 256'(we_issue), 256'(1));
        chk("st_we_pulses", 256'(we_cnt - w0), 256'(1));
        do_req(OP_LD, 32'h100, 16'h0, 16'h0, 256'h0);
        chk("ld_lat", 256'(lat), 256'(3));
        chk("ld_data", 256'(da), 256'(16'hBEEF));
        chk("ld_err", 256'(er), 256'(0));

        // Vector store then load
        for (int i = 0; i < 16; i++) pat[16*i +: 16] = 16'(i + 1);
        do_req(OP_VST, 32'h20, 16'h0, 16'h0, pat);
        chk("vst_sel", 256'(sel), 256'(1));
        chk("vst_err", 256'(er), 256'(0));
        do_req(OP_VLD, 32'h20, 16'h0, 16'h0, 256'h0);
        chk("vld_sel", 256'(sel), 256'(1));
        chk("vld_lat", 256'(lat), 256'(3));
        chk("vld_data", db, pat);

        // Strided gather over preloaded words
        for (int i = 0; i < 16; i++) begin
            do_req(OP_ST, 32'h10 + 32'(4*i), 16'h0, 16'hA000 + 16'(i), 256'h0);
            gexp[16*i +: 16] = 16'hA000 + 16'(i);
        end
        w0 = we_cnt;
        do_req(OP_GATHER, 32'h10, 16'd4, 16'h0, 256'h0);
        chk("gather_lat", 256'(lat), 256'(18));
        chk("gather_data", db, gexp);
        chk("gather_err", 256'(er), 256'(0));
        chk("gather_no_write", 256'(we_cnt - w0), 256'(0));

        // Out-of-range and illegal accesses
        do_req(OP_LD, 32'h0004_0000, 16'h0, 16'h0, 256'h0);
        chk("ld_oor_err", 256'(er), 256'(1));
        chk("ld_oor_data", 256'(da), 256'(0));
        chk("ld_oor_lat", 256'(lat), 256'(3));
        do_req(OP_VLD, 32'h0000_4000, 16'h0, 16'h0, 256'h0);
        chk("vld_oor_err", 256'(er), 256'(1));
        chk("vld_oor_data", db, 256'h0);
        w0 = we_cnt;
        do_req(OP_ST, 32'h0004_0000, 16'h0, 16'h1234, 256'h0);
        chk("st_oor_err", 256'(er), 256'(1));
        chk("st_oor_no_write", 256'(we_cnt - w0), 256'(0));
        do_req(3'b101, 32'h0, 16'h0, 16'h0, 256'h0);
        chk("illegal_err", 256'(er), 256'(1));
        chk("illegal_lat", 256'(lat), 256'(2));

        // Gather running off the top of the scalar range
        do_req(OP_ST, 32'h3FFF0, 16'h0, 16'h1111, 256'h0);
        do_req(OP_ST, 32'h3FFF8, 16'h0, 16'h2222, 256'h0);
        gexp = 256'h0;
        gexp[15:0] = 16'h1111;
        gexp[31:16] = 16'h2222;
        do_req(OP_GATHER, 32'h3FFF0, 16'd8, 16'h0, 256'h0);
        chk("gather_oor_data", db, gexp);
        chk("gather_oor_err", 256'(er), 256'(1));
        chk("gather_oor_lat", 256'(lat), 256'(18));

        // Gather whose lane addresses wrap past 2^32 back into range
        do_req(OP_GATHER, 32'hFFFF_FFF0, 16'h0020, 16'h0, 256'h0);
        chk("gather_wrap_low", 256'(db[47:0]), 256'(48'hA008_A000_0000));
        chk("gather_wrap_err", 256'(er), 256'(1));

        // Reset asserted during a vector-store ISSUE cycle
        req_op = OP_VST; req_addr = 32'h30; req_wdata_b = pat; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("vst2_we_issue", 256'(mem_w_enable), 256'(1));
        w0 = we_cnt;
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_we_drop", 256'(mem_w_enable), 256'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_req_ready", 256'(req_ready), 256'(1));
        chk("rst_mid_no_write", 256'(we_cnt - w0), 256'(0));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_no_rsp", 256'(rsp_valid), 256'(0));

        // Response back-pressure on a load
        rsp_ready = 1'b0;
        do_req(OP_LD, 32'h100, 16'h0, 16'h0, 256'h0);
        chk("stall_ld_lat", 256'(lat), 256'(3));
        chk("stall_ld_data", 256'(da), 256'(16'hBEEF));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid_held", 256'(rsp_valid), 256'(1));
            chk("stall_data_held", 256'(rsp_data_a), 256'(16'hBEEF));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_rsp_done", 256'(rsp_valid), 256'(0));
        chk("stall_req_ready", 256'(req_ready), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
